// File: rtl/mem_arb_defs.sv
// Shared encodings for the IF/MEM memory-port arbiter: FSM states, grant
// owner, and the legal range of the memory read latency.
package mem_arb_defs;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    // Latency counter width; a 4-bit counter covers latencies 1..15.
    localparam int LAT_W = 4;

    function automatic bit mem_lat_ok(input int lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear and count enable;
// clear takes priority over enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_n_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch and the
// data stage, returns read data with a one-cycle ack and reports pipeline stall.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [31:0]       stall_cnt_o
);

    if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_dm_q, last_dm_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_wins;

    // Handshake: a port raises req and holds it (with stable address/data)
    // until its ack; ack is a single-cycle pulse, and a req still high in the
    // following cycle is a new access. Only IDLE samples the request inputs.
    assign dm_wins = dm_req_i && !(if_req_i && last_dm_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_dm_d   = last_dm_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (dm_wins) begin
                    gnt_d       = GNT_DM;
                    last_dm_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    state_d     = ISSUE;
                end else if (if_req_i) begin
                    gnt_d      = GNT_IF;
                    last_dm_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                // The counter reaches zero on this edge: read data is valid now.
                if (cnt_q == LAT_W'(1)) begin
                    if (!mem_we_q) begin
                        if (gnt_q == GNT_DM) dm_rdata_d = mem_rdata_i;
                        else                 if_rdata_d = mem_rdata_i;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            last_dm_q   <= 1'b0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_dm_q   <= last_dm_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_en_o    = (state_q == ISSUE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = (state_q == RESP) && (gnt_q == GNT_IF);
    assign dm_ack_o    = (state_q == RESP) && (gnt_q == GNT_DM);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

    sat_counter #(
        .W(32)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .clr_n_i(rst_i),
        .en_i   (stall_o),
        .cnt_o  (stall_cnt_o)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (latency 2, 1, 15) each with a
// memory model that presents valid data only in the exact latency cycle.
module tb_mem_port_arbiter;

    localparam int NI = 3;
    localparam int LATS[NI] = '{2, 1, 15};
    localparam int ACK_W = 51;  // {inst[2], port_dm, cycle[16], data[32]}
    localparam int ISS_W = 83;  // {inst[2], we, addr[32], wdata[32], cycle[16]}

    logic        clk;
    logic        rst_n;
    logic        if_req[NI], dm_req[NI], dm_we[NI];
    logic [31:0] if_addr[NI], dm_addr[NI], dm_wdata[NI];
    logic [31:0] if_rdata[NI], dm_rdata[NI];
    logic        if_ack[NI], dm_ack[NI];
    logic        mem_en[NI], mem_we[NI];
    logic [31:0] mem_addr[NI], mem_wdata[NI], mem_rdata[NI];
    logic        stall[NI];
    logic [31:0] stall_cnt[NI];

    logic [ACK_W-1:0] exp_q[$];
    logic [ISS_W-1:0] iss_q[$];
    logic [31:0]      if_shadow[NI], dm_shadow[NI];
    int               mcnt[NI];
    logic [31:0]      maddr[NI];
    int               cyc;
    int               n_cmp, n_err;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_rdata_o(if_rdata[0]), .if_ack_o(if_ack[0]),
        .dm_req_i(dm_req[0]), .dm_we_i(dm_we[0]), .dm_addr_i(dm_addr[0]), .dm_wdata_i(dm_wdata[0]),
        .dm_rdata_o(dm_rdata[0]), .dm_ack_o(dm_ack[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rdata_i(mem_rdata[0]), .stall_o(stall[0]), .stall_cnt_o(stall_cnt[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_rdata_o(if_rdata[1]), .if_ack_o(if_ack[1]),
        .dm_req_i(dm_req[1]), .dm_we_i(dm_we[1]), .dm_addr_i(dm_addr[1]), .dm_wdata_i(dm_wdata[1]),
        .dm_rdata_o(dm_rdata[1]), .dm_ack_o(dm_ack[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rdata_i(mem_rdata[1]), .stall_o(stall[1]), .stall_cnt_o(stall_cnt[1])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req[2]), .if_addr_i(if_addr[2]), .if_rdata_o(if_rdata[2]), .if_ack_o(if_ack[2]),
        .dm_req_i(dm_req[2]), .dm_we_i(dm_we[2]), .dm_addr_i(dm_addr[2]), .dm_wdata_i(dm_wdata[2]),
        .dm_rdata_o(dm_rdata[2]), .dm_ack_o(dm_ack[2]),
        .mem_en_o(mem_en[2]), .mem_we_o(mem_we[2]), .mem_addr_o(mem_addr[2]), .mem_wdata_o(mem_wdata[2]),
        .mem_rdata_i(mem_rdata[2]), .stall_o(stall[2]), .stall_cnt_o(stall_cnt[2])
    );

    // ---------------- helpers ----------------
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Push the expected memory issue and (optionally) the expected ack.
    task automatic push_exp(input int inst, input bit port_dm, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_cyc, input bit with_ack);
        logic [31:0] d;
        int          iss_cyc;
        iss_cyc = ack_cyc - LATS[inst] - 1;
        iss_q.push_back({2'(inst), we, addr, (we ? wdata : 32'h0), 16'(iss_cyc)});
        if (!port_dm) begin
            d = rd_model(addr);
            if_shadow[inst] = d;
        end else if (we) begin
            d = dm_shadow[inst];
        end else begin
            d = rd_model(addr);
            dm_shadow[inst] = d;
        end
        if (with_ack) exp_q.push_back({2'(inst), port_dm, 16'(ack_cyc), d});
    endtask

    // Raise a request and hold it until n acks of that port, bounded.
    task automatic hold_req(input int inst, input bit port_dm, input int n);
        int got;
        int waited;
        got = 0;
        waited = 0;
        if (port_dm) dm_req[inst] = 1'b1;
        else         if_req[inst] = 1'b1;
        while (got < n && waited < 200) begin
            @(negedge clk);
            waited++;
            if (port_dm ? dm_ack[inst] : if_ack[inst]) got++;
        end
        if (port_dm) dm_req[inst] = 1'b0;
        else         if_req[inst] = 1'b0;
        if (got < n) check_eq("ack_timeout", 128'(got), 128'(n));
    endtask

    // ---------------- memory models ----------------
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            mem_rdata[i] = $urandom;
            if (mcnt[i] > 0) begin
                mcnt[i] = mcnt[i] - 1;
                if (mcnt[i] == 0) mem_rdata[i] = rd_model(maddr[i]);
            end
            if (mem_en[i]) begin
                mcnt[i]  = LATS[i];
                maddr[i] = mem_addr[i];
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                if (mem_en[i]) begin
                    if (iss_q.size() == 0) check_eq("issue_unexpected", 128'(1), 128'(0));
                    else check_eq("issue", 128'({2'(i), mem_we[i], mem_addr[i],
                                                 (mem_we[i] ? mem_wdata[i] : 32'h0), 16'(cyc)}),
                                  128'(iss_q.pop_front()));
                end
                if (if_ack[i] || dm_ack[i]) begin
                    check_eq("ack_exclusive", 128'(if_ack[i] & dm_ack[i]), 128'(0));
                    if (exp_q.size() == 0) check_eq("ack_unexpected", 128'(1), 128'(0));
                    else check_eq("ack", 128'({2'(i), dm_ack[i], 16'(cyc),
                                               (dm_ack[i] ? dm_rdata[i] : if_rdata[i])}),
                                  128'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if_req[i] = 1'b0; dm_req[i] = 1'b0; dm_we[i] = 1'b0;
            if_addr[i] = '0; dm_addr[i] = '0; dm_wdata[i] = '0;
            if_shadow[i] = '0; dm_shadow[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_eq("reset_ctrl", 128'({mem_en[i], mem_we[i], if_ack[i], dm_ack[i], stall_cnt[i]}), 128'(0));
            check_eq("reset_data", {mem_addr[i], mem_wdata[i], if_rdata[i], dm_rdata[i]}, 128'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Lone fetch.
        t0 = cyc;
        if_addr[0] = 32'h10;
        push_exp(0, 1'b0, 1'b0, 32'h10, 32'h0, t0 + 4, 1'b1);
        hold_req(0, 1'b0, 1);
        check_eq("stall_cnt_fetch", 128'(stall_cnt[0]), 128'(4));

        // Fetch and data read together: data first.
        @(negedge clk);
        t0 = cyc;
        dm_addr[0] = 32'h100; dm_we[0] = 1'b0; if_addr[0] = 32'h200;
        push_exp(0, 1'b1, 1'b0, 32'h100, 32'h0, t0 + 4, 1'b1);
        push_exp(0, 1'b0, 1'b0, 32'h200, 32'h0, t0 + 9, 1'b1);
        fork
            hold_req(0, 1'b1, 1);
            hold_req(0, 1'b0, 1);
        join

        // Both held across two grants each: DM, IF, DM, IF.
        @(negedge clk);
        t0 = cyc;
        dm_addr[0] = 32'h104; if_addr[0] = 32'h204;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_exp(0, 1'b1, 1'b0, 32'h104, 32'h0, t0 + 4 + 5 * k, 1'b1);
            else            push_exp(0, 1'b0, 1'b0, 32'h204, 32'h0, t0 + 4 + 5 * k, 1'b1);
        end
        fork
            hold_req(0, 1'b1, 2);
            hold_req(0, 1'b0, 2);
        join

        // Data write: rdata must stay at the last read value.
        @(negedge clk);
        t0 = cyc;
        dm_we[0] = 1'b1; dm_addr[0] = 32'h0C; dm_wdata[0] = 32'd18;
        push_exp(0, 1'b1, 1'b1, 32'h0C, 32'd18, t0 + 4, 1'b1);
        hold_req(0, 1'b1, 1);
        dm_we[0] = 1'b0;

        // Reset during WAIT: access is dropped, no ack, then a fresh request.
        @(negedge clk);
        t0 = cyc;
        dm_addr[0] = 32'h300;
        push_exp(0, 1'b1, 1'b0, 32'h300, 32'h0, t0 + 4, 1'b0);
        dm_req[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_ctrl", 128'({mem_en[0], mem_we[0], if_ack[0], dm_ack[0], stall_cnt[0]}), 128'(0));
        check_eq("rst_mid_data", {mem_addr[0], mem_wdata[0], if_rdata[0], dm_rdata[0]}, 128'(0));
        check_eq("rst_stall_live", 128'(stall[0]), 128'(1));
        @(negedge clk);
        check_eq("rst_stall_cnt_hold", 128'(stall_cnt[0]), 128'(0));
        if_shadow[0] = '0;
        dm_shadow[0] = '0;
        rst_n = 1'b1;
        t0 = cyc;
        push_exp(0, 1'b1, 1'b0, 32'h300, 32'h0, t0 + 4, 1'b1);
        hold_req(0, 1'b1, 1);
        check_eq("stall_cnt_after_rst", 128'(stall_cnt[0]), 128'(4));

        // Latency extremes.
        @(negedge clk);
        t0 = cyc;
        if_addr[1] = 32'h20;
        push_exp(1, 1'b0, 1'b0, 32'h20, 32'h0, t0 + 3, 1'b1);
        hold_req(1, 1'b0, 1);
        @(negedge clk);
        t0 = cyc;
        dm_addr[2] = 32'h40;
        push_exp(2, 1'b1, 1'b0, 32'h40, 32'h0, t0 + 17, 1'b1);
        hold_req(2, 1'b1, 1);

        repeat (5) @(negedge clk);
        check_eq("ack_q_empty", 128'(exp_q.size()), 128'(0));
        check_eq("iss_q_empty", 128'(iss_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
